backprop_unit: RTL and testbench
================================

// Module: backprop_unit
// PURPOSE
//   Backward-pass engine for the 2-hidden/1-output network. After a forward pass it takes
//   the output error, the hidden activations and the input nibble, then updates the
//   output-layer weights (2) and hidden-layer weights (2 neurons x 4) one per cycle.
//   Updates use a single shared multiplier. Weight registers live here and feed the
//   neuron w*_i ports. start/busy/done handshake driven by the training sequencer.
// PARAMETERS
//   W_W       8    weight width, signed two's complement
//   ERR_W     16   error width, signed
//   ACT_W     10   hidden activation width, unsigned
//   LR_SHIFT  8    learning rate = 2^-LR_SHIFT (arithmetic right shift)
//   WO0_INIT  5    reset value of output weight 0;  WO1_INIT 8 (output weight 1)
//   WH_INIT   {4,3,2,1}  reset values of hidden w3..w0, identical for both neurons
// PORTS
//   clk_i      in   1        clock, rising edge
//   rst_i      in   1        asynchronous reset, active low
//   en_i       in   1        clock enable; low freezes FSM and all registers
//   start_i    in   1        begin update; accepted only in IDLE with en_i=1
//   err_i      in   ERR_W    signed output error (prediction - target)
//   a0_i,a1_i  in   ACT_W    hidden neuron 0/1 activations
//   x_i        in   4        input nibble fed to hidden neurons
//   busy_o     out  1        update in progress
//   done_o     out  1        one-cycle pulse: all 10 weights updated
//   wo0_o,wo1_o out W_W      output-layer weights
//   wh_o       out  8*W_W    hidden weights; neuron j weight i at [W_W*(4*j+i) +: W_W]
// BEHAVIOUR
//   Reset (async, rst_i=0): FSM=IDLE, busy_o=0, done_o=0, wo0_o=WO0_INIT,
//     wo1_o=WO1_INIT, every hidden weight i = WH_INIT[i]; operand latches cleared.
//   FSM IDLE -> OUT -> HID -> DONE -> IDLE; only transitions when en_i=1.
//   IDLE: on start_i=1 latch err_i, a0_i, a1_i, x_i; go OUT, k=0. start_i ignored elsewhere.
//   OUT (2 cycles, k=0,1): delta_h[k] = err * wo_k (pre-update value, 24b signed, stored);
//     g = (err * {1'b0,a_k}) >>> LR_SHIFT (27b product); wo_k <= sat(wo_k - g).
//   HID (8 cycles, j=0..1 outer, i=0..3 inner): if x[i]=1 then
//     wh[j][i] <= sat(wh[j][i] - (delta_h[j] >>> LR_SHIFT)); else unchanged.
//   DONE (1 cycle): done_o=1; next cycle IDLE, done_o=0.
//   sat(): clamp full-width result to [-2^(W_W-1), 2^(W_W-1)-1]; compute in >=28b, no wrap.
//   Timing: start accepted at edge 0 -> OUT cycles 1-2, HID 3-10, done_o high cycle 11.
//     busy_o=1 from cycle 1 through cycle 11 inclusive; 0 in IDLE.
//   en_i=0: state, counters, weights, done_o all held; latency extends 1 cycle per stall.
//   Inputs err_i/a*_i/x_i may change after acceptance; only latched copies are used.
//   err=0: every weight unchanged, full sequence and done_o still occur.
//   Reset mid-operation: immediate return to reset values; partial updates discarded.
//   Outputs are registered; wo*/wh_o update on the edge ending the corresponding cycle.
// TESTING
//   1 Reset release -> wo0=5, wo1=8, wh=[1,2,3,4] both neurons, busy=0, done=0.
//   2 err=256,a0=1,a1=2,x=0000,start -> wo0=4, wo1=6, wh unchanged, done_o at cycle 11 only.
//   3 err=256,a0=a1=0,x=0001 -> wo unchanged; wh[0][0]=1-5=-4, wh[1][0]=1-8=-7, rest same.
//   4 err=-32768,a0=1023,a1=0,x=0000 -> wo0 saturates to 127, wo1=8; err=32767,a0=1023 next -> wo0 clamps to -128.
//   5 start held high during busy + en_i=0 for 3 cycles mid-HID -> single update only, done_o at cycle 14.
//   6 rst_i low at cycle 5 of test 3 stimulus -> all weights back to init, busy=0, no done_o.

Source files
------------

// File: rtl/backprop_unit.sv
// Backward-pass engine: updates 2 output and 8 hidden weights, one per cycle,
// from latched error, activations and input nibble.
module backprop_unit #(
   parameter int W_W      = 8,
   parameter int ERR_W    = 16,
   parameter int ACT_W    = 10,
   parameter int LR_SHIFT = 8,
   parameter int WO0_INIT = 5,
   parameter int WO1_INIT = 8,
   parameter logic [4*W_W-1:0] WH_INIT = {8'd4, 8'd3, 8'd2, 8'd1}
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               start_i,
   input  logic [ERR_W-1:0]   err_i,
   input  logic [ACT_W-1:0]   a0_i,
   input  logic [ACT_W-1:0]   a1_i,
   input  logic [3:0]         x_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [W_W-1:0]     wo0_o,
   output logic [W_W-1:0]     wo1_o,
   output logic [8*W_W-1:0]   wh_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OUT  = 2'd1;
   localparam logic [1:0] S_HID  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int PW = ERR_W + ACT_W + 1;
   localparam int DW = ERR_W + W_W;
   localparam int CW = PW + 1;
   localparam logic signed [CW-1:0] MAXV = CW'((2 ** (W_W - 1)) - 1);
   localparam logic signed [CW-1:0] MINV = -MAXV - CW'(1);

   logic [1:0]              state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic [ACT_W-1:0]        a0_q, a0_d, a1_q, a1_d;
   logic [3:0]              x_q, x_d;
   logic signed [DW-1:0]    dh0_q, dh0_d, dh1_q, dh1_d;
   logic signed [W_W-1:0]   wo0_q, wo0_d, wo1_q, wo1_d;
   logic signed [W_W-1:0]   wh_q [8];
   logic signed [W_W-1:0]   wh_d [8];

   logic signed [ACT_W:0]   mul_b;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    grad;
   logic signed [W_W-1:0]   wo_sel;
   logic signed [DW-1:0]    dprod;
   logic signed [DW-1:0]    dsel;
   logic signed [DW-1:0]    dsh;
   logic signed [CW-1:0]    wo_new;
   logic signed [CW-1:0]    wh_new;

   function automatic logic signed [W_W-1:0] sat(input logic signed [CW-1:0] v);
      if (v > MAXV) return MAXV[W_W-1:0];
      if (v < MINV) return MINV[W_W-1:0];
      return v[W_W-1:0];
   endfunction

   // The gradient multiplier is time-shared between the two output weights via k
   always_comb begin
      mul_b  = cnt_q[0] ? $signed({1'b0, a1_q}) : $signed({1'b0, a0_q});
      prod   = err_q * mul_b;
      grad   = prod >>> LR_SHIFT;
      wo_sel = cnt_q[0] ? wo1_q : wo0_q;
      dprod  = err_q * wo_sel;
      wo_new = CW'(wo_sel) - CW'(grad);
      dsel   = cnt_q[2] ? dh1_q : dh0_q;
      dsh    = dsel >>> LR_SHIFT;
      wh_new = CW'(wh_q[cnt_q]) - CW'(dsh);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      a0_d    = a0_q;
      a1_d    = a1_q;
      x_d     = x_q;
      dh0_d   = dh0_q;
      dh1_d   = dh1_q;
      wo0_d   = wo0_q;
      wo1_d   = wo1_q;
      wh_d    = wh_q;
      if (en_i) begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  err_d   = $signed(err_i);
                  a0_d    = a0_i;
                  a1_d    = a1_i;
                  x_d     = x_i;
                  cnt_d   = 3'd0;
                  state_d = S_OUT;
               end
            end
            S_OUT: begin
               if (cnt_q[0]) begin
                  dh1_d = dprod;
                  wo1_d = sat(wo_new);
               end else begin
                  dh0_d = dprod;
                  wo0_d = sat(wo_new);
               end
               if (cnt_q[0]) begin
                  cnt_d   = 3'd0;
                  state_d = S_HID;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_HID: begin
               if (x_q[cnt_q[1:0]]) wh_d[cnt_q] = sat(wh_new);
               if (cnt_q == 3'd7) begin
                  cnt_d   = 3'd0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         a0_q    <= '0;
         a1_q    <= '0;
         x_q     <= '0;
         dh0_q   <= '0;
         dh1_q   <= '0;
         wo0_q   <= W_W'(WO0_INIT);
         wo1_q   <= W_W'(WO1_INIT);
         for (int i = 0; i < 8; i++) begin
            wh_q[i] <= WH_INIT[W_W*(i%4) +: W_W];
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         x_q     <= x_d;
         dh0_q   <= dh0_d;
         dh1_q   <= dh1_d;
         wo0_q   <= wo0_d;
         wo1_q   <= wo1_d;
         for (int i = 0; i < 8; i++) begin
            wh_q[i] <= wh_d[i];
         end
      end
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);
   assign wo0_o  = wo0_q;
   assign wo1_o  = wo1_q;

   for (genvar g = 0; g < 8; g++) begin : g_wh
      assign wh_o[W_W*g +: W_W] = wh_q[g];
   end

endmodule

// File: tb/tb_backprop_unit.sv
// Directed bench for backprop_unit: weight updates, saturation, stalls,
// held start and mid-operation reset.
module tb_backprop_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        en_i = 1'b1;
   logic        start_i = 1'b0;
   logic [15:0] err_i = '0;
   logic [9:0]  a0_i = '0;
   logic [9:0]  a1_i = '0;
   logic [3:0]  x_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  wo0_o;
   logic [7:0]  wo1_o;
   logic [63:0] wh_o;

   int n_assert = 0;
   int n_fail = 0;

   localparam logic [63:0] WH_RST = 64'h04030201_04030201;
   localparam logic [63:0] WH_T3  = 64'h040302F9_040302FC;

   backprop_unit dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .start_i(start_i),
      .err_i  (err_i),
      .a0_i   (a0_i),
      .a1_i   (a1_i),
      .x_i    (x_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .wo0_o  (wo0_o),
      .wo1_o  (wo1_o),
      .wh_o   (wh_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      en_i = 1'b1;
      start_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic chk_w(input string tag, input logic [7:0] e0,
                        input logic [7:0] e1, input logic [63:0] eh);
      chk({tag, "_wo0"}, wo0_o, e0);
      chk({tag, "_wo1"}, wo1_o, e1);
      chk({tag, "_wh"}, wh_o, eh);
   endtask

   // Starts one update and checks busy/done every cycle up to done_cyc+1.
   task automatic run_op(input string tag, input logic [15:0] e,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [3:0] x, input int st_at,
                         input int st_len, input bit hold,
                         input int done_cyc);
      err_i = e;
      a0_i = a0;
      a1_i = a1;
      x_i = x;
      start_i = 1'b1;
      @(negedge clk_i);
      if (!hold) start_i = 1'b0;
      err_i = ~e;
      a0_i = ~a0;
      a1_i = ~a1;
      x_i = ~x;
      for (int n = 1; n <= done_cyc + 1; n++) begin
         chk($sformatf("%s_busy_c%0d", tag, n), busy_o, n <= done_cyc);
         chk($sformatf("%s_done_c%0d", tag, n), done_o, n == done_cyc);
         en_i = !(n >= st_at && n < st_at + st_len);
         if (n == done_cyc) start_i = 1'b0;
         @(negedge clk_i);
      end
      en_i = 1'b1;
   endtask

   initial begin
      bit seen_done;

      // 1: reset values
      do_reset();
      chk_w("rst", 8'd5, 8'd8, WH_RST);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);

      // 2: output weights only
      run_op("t2", 16'd256, 10'd1, 10'd2, 4'b0000, 0, 0, 1'b0, 11);
      chk_w("t2", 8'd4, 8'd6, WH_RST);

      // 3: hidden weight 0 of each neuron
      do_reset();
      run_op("t3", 16'd256, 10'd0, 10'd0, 4'b0001, 0, 0, 1'b0, 11);
      chk_w("t3", 8'd5, 8'd8, WH_T3);

      // 4: saturation both directions, then zero error
      do_reset();
      run_op("t4a", 16'h8000, 10'd1023, 10'd0, 4'b0000, 0, 0, 1'b0, 11);
      chk_w("t4a", 8'h7F, 8'd8, WH_RST);
      run_op("t4b", 16'd32767, 10'd1023, 10'd0, 4'b0000, 0, 0, 1'b0, 11);
      chk_w("t4b", 8'h80, 8'd8, WH_RST);
      run_op("t4z", 16'd0, 10'd1023, 10'd1023, 4'b1111, 0, 0, 1'b0, 11);
      chk_w("t4z", 8'h80, 8'd8, WH_RST);

      // 5: held start and a 3-cycle stall mid-HID
      do_reset();
      run_op("t5", 16'd256, 10'd1, 10'd2, 4'b0000, 5, 3, 1'b1, 14);
      chk_w("t5", 8'd4, 8'd6, WH_RST);
      repeat (3) @(negedge clk_i);
      chk("t5_idle", busy_o, 1'b0);
      chk_w("t5_end", 8'd4, 8'd6, WH_RST);

      // 6: reset during HID
      do_reset();
      err_i = 16'd256;
      a0_i = 10'd0;
      a1_i = 10'd0;
      x_i = 4'b0001;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("t6_partial_wh", wh_o, 64'h04030201_040302FC);
      chk("t6_busy_pre", busy_o, 1'b1);
      rst_i = 1'b0;
      #1;
      chk_w("t6_rst", 8'd5, 8'd8, WH_RST);
      chk("t6_busy", busy_o, 1'b0);
      chk("t6_done", done_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      seen_done = 1'b0;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk_i);
         if (done_o) seen_done = 1'b1;
      end
      chk("t6_no_done", seen_done, 1'b0);
      chk("t6_idle", busy_o, 1'b0);
      chk_w("t6_end", 8'd5, 8'd8, WH_RST);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
